// File: rtl/sdhci_dat_pkg.sv
// Shared constants and state encoding for the SD DAT-line write path.
// Imported by the per-lane CRC register and the multilane framer.
package sdhci_dat_pkg;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam int          CRC16_LEN  = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      CRC,
      END,
      RELEASE
   } dat_wr_state_e;

endpackage

// File: rtl/crc16_multilane_write_if.sv
// Bundle between the write-data buffer / SD clock generator (master) and the
// DAT-line framer (slave). clk and reset stay outside as plain ports.
interface crc16_multilane_write_if #(
   parameter int NUM_LANES = 4,
   parameter int BLK_LEN_W = 12
);

   logic                 clk_en_i;
   logic                 start_i;
   logic [BLK_LEN_W-1:0] block_len_i;
   logic                 wide_i;
   logic [NUM_LANES-1:0] data_i;
   logic                 data_valid_i;
   logic                 data_ready_o;
   logic [NUM_LANES-1:0] dat_o;
   logic [NUM_LANES-1:0] dat_oe_o;
   logic                 busy_o;
   logic                 done_o;
   logic                 underrun_o;

   modport master (
      output clk_en_i, start_i, block_len_i, wide_i, data_i, data_valid_i,
      input  data_ready_o, dat_o, dat_oe_o, busy_o, done_o, underrun_o
   );

   modport slave (
      input  clk_en_i, start_i, block_len_i, wide_i, data_i, data_valid_i,
      output data_ready_o, dat_o, dat_oe_o, busy_o, done_o, underrun_o
   );

endinterface

// File: rtl/crc16_lane.sv
// Serial CRC16 (x^16+x^12+x^5+1) register for one DAT lane. The same register
// either absorbs data bits or shifts its contents out MSB first.
module crc16_lane
   import sdhci_dat_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic en,
   input  logic clr,
   input  logic shift_out,
   input  logic bit_in,
   output logic msb
);

   logic [CRC16_LEN-1:0] crc;
   logic                 fb;

   assign fb  = bit_in ^ crc[CRC16_LEN-1];
   assign msb = crc[CRC16_LEN-1];

   always_ff @(posedge clk_i) begin
      if (rst_i || clr) begin
         crc <= '0;
      end else if (en) begin
         // Zero fill during shift-out leaves the register clean for the next block.
         if (shift_out) crc <= {crc[CRC16_LEN-2:0], 1'b0};
         else           crc <= {crc[CRC16_LEN-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
      end
   end

endmodule

// File: rtl/crc16_multilane_write.sv
// SD DAT-line write framer: start bit, data beats, per-lane CRC16, end bit,
// then release. Line state advances only on clk_en_i ticks.
module crc16_multilane_write
   import sdhci_dat_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int BLK_LEN_W = 12
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   crc16_multilane_write_if.slave  bus
);

   localparam int CNT_W   = BLK_LEN_W + 3;
   localparam int LANE_SH = $clog2(NUM_LANES);

   dat_wr_state_e        state;
   logic [CNT_W-1:0]     cnt;
   logic [3:0]           crc_cnt;
   logic [BLK_LEN_W-1:0] len_q;
   logic                 wide_q;
   logic [NUM_LANES-1:0] mask;
   logic [CNT_W-1:0]     bit_total;
   logic [CNT_W-1:0]     beats;
   logic                 start_ok;
   logic                 shift_crc;
   logic [NUM_LANES-1:0] lane_en;
   logic [NUM_LANES-1:0] crc_msb;

   assign mask      = wide_q ? {NUM_LANES{1'b1}} : NUM_LANES'(1);
   assign bit_total = {len_q, 3'b000};
   assign beats     = wide_q ? (bit_total >> LANE_SH) : bit_total;
   assign start_ok  = (state == IDLE) && bus.start_i && (bus.block_len_i != '0);
   assign shift_crc = (state == CRC);

   // Combinational so the buffer can pop in the same cycle the beat is taken.
   assign bus.data_ready_o = (state == DATA) && bus.clk_en_i;
   assign bus.busy_o       = (state != IDLE);

   always_comb begin
      lane_en = '0;
      if (bus.clk_en_i && ((state == DATA && bus.data_valid_i) || state == CRC))
         lane_en = mask;
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      crc16_lane u_lane (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .en        (lane_en[k]),
         .clr       (start_ok),
         .shift_out (shift_crc),
         .bit_in    (bus.data_i[k]),
         .msb       (crc_msb[k])
      );
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would chain through the case arms.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         cnt            <= '0;
         crc_cnt        <= '0;
         len_q          <= '0;
         wide_q         <= 1'b0;
         bus.dat_o      <= '1;
         bus.dat_oe_o   <= '0;
         bus.done_o     <= 1'b0;
         bus.underrun_o <= 1'b0;
      end else begin
         bus.done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  len_q          <= bus.block_len_i;
                  wide_q         <= bus.wide_i;
                  bus.underrun_o <= 1'b0;
                  state          <= START;
               end
            end
            START: begin
               if (bus.clk_en_i) begin
                  bus.dat_o    <= ~mask;
                  bus.dat_oe_o <= mask;
                  cnt          <= beats - CNT_W'(1);
                  state        <= DATA;
               end
            end
            DATA: begin
               if (bus.clk_en_i) begin
                  if (bus.data_valid_i) begin
                     bus.dat_o <= (bus.data_i & mask) | ~mask;
                     if (cnt == '0) begin
                        crc_cnt <= 4'd15;
                        state   <= CRC;
                     end else begin
                        cnt <= cnt - CNT_W'(1);
                     end
                  end else begin
                     // Starved: close the frame early; the receiver sees a bad CRC.
                     bus.underrun_o <= 1'b1;
                     bus.dat_o      <= '1;
                     state          <= END;
                  end
               end
            end
            CRC: begin
               if (bus.clk_en_i) begin
                  bus.dat_o <= (crc_msb & mask) | ~mask;
                  if (crc_cnt == 4'd0) state <= END;
                  else                 crc_cnt <= crc_cnt - 4'd1;
               end
            end
            END: begin
               if (bus.clk_en_i) begin
                  bus.dat_o <= '1;
                  state     <= RELEASE;
               end
            end
            RELEASE: begin
               if (bus.clk_en_i) begin
                  bus.dat_oe_o <= '0;
                  bus.done_o   <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_crc16_multilane_write.sv
// Bench for crc16_multilane_write: random and fixed blocks checked against a
// bit-level line model and known SD CRC16 values.
module tb_crc16_multilane_write;

   localparam int NL  = 4;
   localparam int BLW = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   crc16_multilane_write_if #(.NUM_LANES(NL), .BLK_LEN_W(BLW)) bus ();

   crc16_multilane_write #(.NUM_LANES(NL), .BLK_LEN_W(BLW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int checks = 0;
   int passes = 0;

   logic [NL-1:0] beat_q[$];
   logic [NL-1:0] rec_dat[$];
   logic [NL-1:0] rec_oe[$];
   logic [NL-1:0] exp_dat[$];
   logic [NL-1:0] exp_oe[$];
   logic [15:0]   exp_crc[NL];
   int            done_cnt;
   bit            timed_out;
   logic          uf_after_start;

   function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
      logic [15:0] n;
      n = c << 1;
      if (b ^ c[15]) n = n ^ 16'h1021;
      return n;
   endfunction

   function automatic int nbeats_of(input int len, input bit wide);
      return wide ? (len * 8) / NL : len * 8;
   endfunction

   // Expected line value after every clk_en tick while busy, from the framing rules.
   task automatic build_expected(input int len, input bit wide, input int abort_beat);
      logic [NL-1:0] m;
      logic [NL-1:0] v;
      int n, used;
      m = wide ? {NL{1'b1}} : NL'(1);
      n = nbeats_of(len, wide);
      used = (abort_beat >= 0) ? abort_beat : n;
      exp_dat.delete();
      exp_oe.delete();
      exp_dat.push_back(~m); exp_oe.push_back(m);
      for (int i = 0; i < used; i++) begin
         exp_dat.push_back((beat_q[i] & m) | ~m);
         exp_oe.push_back(m);
      end
      if (abort_beat >= 0) begin
         exp_dat.push_back('1); exp_oe.push_back(m);
      end else begin
         for (int k = 0; k < NL; k++) begin
            exp_crc[k] = 16'h0000;
            for (int i = 0; i < n; i++) exp_crc[k] = crc_bit(exp_crc[k], beat_q[i][k]);
         end
         for (int b = 15; b >= 0; b--) begin
            v = '1;
            for (int k = 0; k < NL; k++) if (m[k]) v[k] = exp_crc[k][b];
            exp_dat.push_back(v); exp_oe.push_back(m);
         end
      end
      exp_dat.push_back('1); exp_oe.push_back(m);
      exp_dat.push_back('1); exp_oe.push_back('0);
   endtask

   function automatic int seq_first_diff();
      if (rec_dat.size() != exp_dat.size()) return 100000 + rec_dat.size();
      for (int i = 0; i < rec_dat.size(); i++)
         if (rec_dat[i] !== exp_dat[i] || rec_oe[i] !== exp_oe[i]) return i;
      return -1;
   endfunction

   function automatic logic [15:0] dut_crc(input int lane, input int n);
      logic [15:0] c = 16'h0000;
      for (int j = 0; j < 16; j++)
         if (1 + n + j < rec_dat.size()) c = {c[14:0], rec_dat[1 + n + j][lane]};
      return c;
   endfunction

   // Drives one block from beat_q and records the line after each busy clk_en tick.
   task automatic run_block(input int len, input bit wide, input int en_period, input int abort_beat);
      int  idx = 0;
      int  cyc = 0;
      int  n;
      bit  adv, cons;
      bit  fin = 0;
      n = nbeats_of(len, wide);
      rec_dat.delete();
      rec_oe.delete();
      done_cnt  = 0;
      timed_out = 0;
      @(negedge clk);
      bus.start_i     = 1'b1;
      bus.block_len_i = BLW'(len);
      bus.wide_i      = wide;
      while (!fin) begin
         bus.clk_en_i = ((cyc % en_period) == 0);
         if (idx == abort_beat) begin
            bus.data_valid_i = 1'b0;
            bus.data_i       = NL'($urandom);
         end else if (idx < n) begin
            bus.data_valid_i = 1'b1;
            bus.data_i       = beat_q[idx];
         end else begin
            bus.data_valid_i = 1'($urandom);
            bus.data_i       = NL'($urandom);
         end
         #1;
         adv  = bus.clk_en_i && bus.busy_o;
         cons = bus.data_ready_o;
         @(posedge clk);
         @(negedge clk);
         if (cons) idx++;
         if (adv) begin
            rec_dat.push_back(bus.dat_o);
            rec_oe.push_back(bus.dat_oe_o);
         end
         if (cyc == 0) begin
            uf_after_start  = bus.underrun_o;
            bus.block_len_i = BLW'($urandom_range(1, 4095));
            bus.wide_i      = 1'($urandom);
         end
         if (bus.done_o) begin
            done_cnt++;
            fin = 1;
            bus.start_i = 1'b0;
         end
         cyc++;
         if (cyc > 20000) begin
            timed_out   = 1;
            fin         = 1;
            bus.start_i = 1'b0;
         end
      end
      repeat (3) begin
         bus.clk_en_i = 1'($urandom);
         @(negedge clk);
         if (bus.done_o) done_cnt++;
      end
   endtask

   task automatic test_reset();
      bus.clk_en_i = 1'b1; bus.start_i = 1'b0; bus.block_len_i = '0; bus.wide_i = 1'b0;
      bus.data_i = '0; bus.data_valid_i = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.dat_o !== 4'hF) $display("FAIL reset_dat: got %h expected f", bus.dat_o); else passes++;
      checks++; if (bus.dat_oe_o !== 4'h0) $display("FAIL reset_oe: got %h expected 0", bus.dat_oe_o); else passes++;
      checks++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy_o); else passes++;
      checks++; if (bus.done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done_o); else passes++;
      checks++; if (bus.underrun_o !== 1'b0) $display("FAIL reset_underrun: got %b expected 0", bus.underrun_o); else passes++;
      checks++; if (bus.data_ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus.data_ready_o); else passes++;
      rst = 1'b0;
   endtask

   task automatic test_crc_check_string();
      int d;
      logic [15:0] c;
      logic [NL-1:0] bt;
      beat_q.delete();
      for (int b = 0; b < 9; b++)
         for (int j = 7; j >= 0; j--) begin
            bt    = NL'($urandom);
            bt[0] = 1'((8'h31 + b) >> j);
            beat_q.push_back(bt);
         end
      run_block(9, 1'b0, 1, -1);
      build_expected(9, 1'b0, -1);
      d = seq_first_diff();
      checks++; if (d != -1) $display("FAIL str9_line: first bad index %0d of %0d, expected none", d, rec_dat.size()); else passes++;
      c = dut_crc(0, 72);
      checks++; if (c !== 16'h31C3) $display("FAIL str9_crc: got %h expected 31c3", c); else passes++;
      checks++; if (done_cnt != 1) $display("FAIL str9_done: got %0d pulses expected 1", done_cnt); else passes++;
      checks++; if (bus.underrun_o !== 1'b0) $display("FAIL str9_underrun: got %b expected 0", bus.underrun_o); else passes++;
   endtask

   task automatic test_ones_512();
      int d, driven;
      logic [NL-1:0] hi_oe = '0;
      logic [15:0] c;
      beat_q.delete();
      for (int i = 0; i < 4096; i++) beat_q.push_back(NL'($urandom) | NL'(1));
      run_block(512, 1'b0, 1, -1);
      build_expected(512, 1'b0, -1);
      d = seq_first_diff();
      checks++; if (d != -1) $display("FAIL ff512_line: first bad index %0d of %0d, expected none", d, rec_dat.size()); else passes++;
      c = dut_crc(0, 4096);
      checks++; if (c !== 16'h7FA1) $display("FAIL ff512_crc: got %h expected 7fa1", c); else passes++;
      driven = 0;
      foreach (rec_oe[i]) begin
         if (rec_oe[i] != '0) driven++;
         hi_oe = hi_oe | (rec_oe[i] & 4'hE);
      end
      checks++; if (driven != 4114) $display("FAIL ff512_periods: got %0d expected 4114", driven); else passes++;
      checks++; if (hi_oe !== 4'h0) $display("FAIL ff512_idle_lanes_oe: got %h expected 0", hi_oe); else passes++;
      checks++; if (done_cnt != 1) $display("FAIL ff512_done: got %0d pulses expected 1", done_cnt); else passes++;
   endtask

   task automatic test_wide_zeros();
      int d, full;
      logic [15:0] c;
      beat_q.delete();
      for (int i = 0; i < 1024; i++) beat_q.push_back('0);
      run_block(512, 1'b1, 1, -1);
      build_expected(512, 1'b1, -1);
      d = seq_first_diff();
      checks++; if (d != -1) $display("FAIL wide0_line: first bad index %0d of %0d, expected none", d, rec_dat.size()); else passes++;
      for (int k = 0; k < NL; k++) begin
         c = dut_crc(k, 1024);
         checks++; if (c !== 16'h0000) $display("FAIL wide0_crc_lane%0d: got %h expected 0000", k, c); else passes++;
      end
      full = 0;
      foreach (rec_oe[i]) if (rec_oe[i] == 4'hF) full++;
      checks++; if (full != 1042) $display("FAIL wide0_oe_periods: got %0d expected 1042", full); else passes++;
      checks++; if (done_cnt != 1) $display("FAIL wide0_done: got %0d pulses expected 1", done_cnt); else passes++;
   endtask

   task automatic test_clk_en_gaps();
      int d;
      bit same;
      logic [NL-1:0] fast_dat[$];
      logic [NL-1:0] fast_oe[$];
      beat_q.delete();
      for (int i = 0; i < 128; i++) beat_q.push_back(NL'($urandom));
      build_expected(64, 1'b1, -1);
      run_block(64, 1'b1, 1, -1);
      d = seq_first_diff();
      checks++; if (d != -1) $display("FAIL gaps_fast_line: first bad index %0d, expected none", d); else passes++;
      fast_dat = rec_dat;
      fast_oe  = rec_oe;
      run_block(64, 1'b1, 3, -1);
      d = seq_first_diff();
      checks++; if (d != -1) $display("FAIL gaps_slow_line: first bad index %0d, expected none", d); else passes++;
      same = (fast_dat.size() == rec_dat.size());
      if (same) foreach (rec_dat[i]) if (rec_dat[i] !== fast_dat[i] || rec_oe[i] !== fast_oe[i]) same = 0;
      checks++; if (!same) $display("FAIL gaps_slow_vs_fast: got %0d ticks differing, expected identical %0d", rec_dat.size(), fast_dat.size()); else passes++;
      checks++; if (done_cnt != 1) $display("FAIL gaps_done: got %0d pulses expected 1", done_cnt); else passes++;
   endtask

   task automatic test_underrun();
      int d;
      beat_q.delete();
      for (int i = 0; i < 32; i++) beat_q.push_back(NL'($urandom));
      run_block(16, 1'b1, 1, 10);
      build_expected(16, 1'b1, 10);
      d = seq_first_diff();
      checks++; if (d != -1) $display("FAIL under_line: first bad index %0d of %0d, expected none", d, rec_dat.size()); else passes++;
      checks++; if (bus.underrun_o !== 1'b1) $display("FAIL under_flag: got %b expected 1", bus.underrun_o); else passes++;
      checks++; if (done_cnt != 1) $display("FAIL under_done: got %0d pulses expected 1", done_cnt); else passes++;
      beat_q.delete();
      for (int i = 0; i < 16; i++) beat_q.push_back(NL'($urandom));
      run_block(2, 1'b0, 1, -1);
      build_expected(2, 1'b0, -1);
      checks++; if (uf_after_start !== 1'b0) $display("FAIL under_clear_on_start: got %b expected 0", uf_after_start); else passes++;
      d = seq_first_diff();
      checks++; if (d != -1) $display("FAIL under_next_line: first bad index %0d, expected none", d); else passes++;
   endtask

   task automatic test_reset_mid_crc();
      int dn = 0;
      bit any_busy = 0;
      @(negedge clk);
      bus.clk_en_i = 1'b1; bus.data_valid_i = 1'b1; bus.data_i = NL'($urandom);
      bus.wide_i = 1'b0; bus.block_len_i = BLW'(1); bus.start_i = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.start_i = 1'b0;
      repeat (13) begin
         @(posedge clk); @(negedge clk);
         bus.data_i = NL'($urandom);
         if (bus.done_o) dn++;
      end
      checks++; if ({bus.busy_o, bus.dat_oe_o} !== 5'b1_0001) $display("FAIL rst_pre_active: got %b expected 10001", {bus.busy_o, bus.dat_oe_o}); else passes++;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++; if (bus.dat_o !== 4'hF) $display("FAIL rst_mid_dat: got %h expected f", bus.dat_o); else passes++;
      checks++; if (bus.dat_oe_o !== 4'h0) $display("FAIL rst_mid_oe: got %h expected 0", bus.dat_oe_o); else passes++;
      checks++; if (bus.busy_o !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", bus.busy_o); else passes++;
      if (bus.done_o) dn++;
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done_o) dn++;
      end
      checks++; if (dn != 0) $display("FAIL rst_mid_no_done: got %0d pulses expected 0", dn); else passes++;
      bus.block_len_i = '0; bus.start_i = 1'b1; bus.wide_i = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bus.busy_o) any_busy = 1;
      end
      bus.start_i = 1'b0;
      checks++; if (any_busy) $display("FAIL zero_len_busy: got 1 expected 0"); else passes++;
      checks++; if (bus.underrun_o !== 1'b0) $display("FAIL zero_len_underrun: got %b expected 0", bus.underrun_o); else passes++;
   endtask

   initial begin
      test_reset();
      test_crc_check_string();
      test_ones_512();
      test_wide_zeros();
      test_clk_en_gaps();
      test_underrun();
      test_reset_mid_crc();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
